// File: rtl/sam_vid_pkg.sv
// Shared types and constants for the SAMCoupe video prefetch stage.
// SETTLE_CYCLES_DEF is also the figure quoted on the SDRAM controller side.
package sam_vid_pkg;
  localparam int ADDR_W            = 25;
  localparam int WORD_W            = 16;
  localparam int SETTLE_CYCLES_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } fetch_state_t;
endpackage

// File: rtl/sam_vid_fetch_fifo.sv
// Synchronous word FIFO feeding the pixel shifter; head is read combinationally
// from registered storage and forced to zero while empty.
module vid_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (count_r == (AW+1)'(0));
  assign full      = (count_r == (AW+1)'(DEPTH));
  assign do_pop_s  = pop & ~empty;
  // A push into a full FIFO is only taken when the head leaves the same cycle.
  assign do_push_s = push & (~full | do_pop_s);
  assign head      = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];
  assign count     = count_r;

  // Pointer and occupancy tracking; flush overrides any push/pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
    end else if (flush) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      if (do_push_s && !do_pop_s)      count_r <= count_r + (AW+1)'(1);
      else if (do_pop_s && !do_push_s) count_r <= count_r - (AW+1)'(1);
      else                             count_r <= count_r;
    end
  end

  // Word storage.
  always_ff @(posedge clk) begin
    if (do_push_s && !flush) mem_r[wr_ptr_r] <= push_data;
  end
endmodule

// File: rtl/sam_vid_fetch.sv
// Video line prefetcher: issues address pairs to the SDRAM video ports, waits a
// fixed settle time (no data strobe exists) and pushes both words into the FIFO.
module sam_vid_fetch
  import sam_vid_pkg::*;
#(
  parameter int WORDS_PER_LINE = 64,
  parameter int SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              line_start,
  input  logic [ADDR_W-1:0] line_base,
  output logic [ADDR_W-1:0] vid_addr1,
  output logic [ADDR_W-1:0] vid_addr2,
  input  logic [WORD_W-1:0] vid_data1,
  input  logic [WORD_W-1:0] vid_data2,
  input  logic              pix_rd,
  output logic [WORD_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              line_done
);
  localparam int RW = $clog2(WORDS_PER_LINE + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t      state_r, state_s;
  logic              phase_r, abort_r;
  logic [ADDR_W-1:0] base_r, pending_r, new_base_s;
  logic [RW-1:0]     remaining_r;
  logic [SW-1:0]     settle_r;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty;
  logic              free_ok_s, last_pair_s;
  logic              restart_s, issue_s, abort_now_s, record_s, push_s, flush_s, done_s;
  logic [WORD_W-1:0] push_data_s;

  assign new_base_s  = line_base & ~ADDR_W'(1);
  assign free_ok_s   = ~fifo_full & (fifo_count <= CW'(FIFO_DEPTH - 2));
  assign last_pair_s = (remaining_r == RW'(2));
  assign pix_valid   = ~fifo_empty;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= state_s;
  end

  // Next-state logic; a pending restart leaves CAPTURE for ISSUE, not IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (line_start) state_s = ISSUE; else state_s = IDLE;
      ISSUE:   if (line_start) state_s = ISSUE;
               else if (free_ok_s) state_s = WAIT;
               else state_s = ISSUE;
      WAIT:    if (settle_r == SW'(0)) state_s = CAPTURE; else state_s = WAIT;
      CAPTURE: if (!phase_r) state_s = CAPTURE;
               else if (line_start || abort_r || !last_pair_s) state_s = ISSUE;
               else state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Control decode. Once a restart is recorded the in-flight pair is never pushed.
  always_comb begin
    restart_s   = 1'b0;
    issue_s     = 1'b0;
    abort_now_s = 1'b0;
    record_s    = 1'b0;
    push_s      = 1'b0;
    done_s      = 1'b0;
    push_data_s = phase_r ? vid_data2 : vid_data1;
    case (state_r)
      IDLE:    restart_s = line_start;
      ISSUE: begin
        restart_s = line_start;
        issue_s   = ~line_start & free_ok_s;
      end
      WAIT:    record_s = line_start;
      CAPTURE: begin
        push_s = ~line_start & ~abort_r;
        if (phase_r) begin
          abort_now_s = line_start | abort_r;
          done_s      = last_pair_s & ~abort_r;
        end else begin
          record_s = line_start;
        end
      end
      default: restart_s = 1'b0;
    endcase
    flush_s = restart_s | abort_now_s;
  end

  // Line base, pending restart base and remaining-word count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_r      <= ADDR_W'(0);
      pending_r   <= ADDR_W'(0);
      remaining_r <= RW'(0);
      abort_r     <= 1'b0;
    end else if (restart_s) begin
      base_r      <= new_base_s;
      remaining_r <= RW'(WORDS_PER_LINE);
      abort_r     <= 1'b0;
    end else if (abort_now_s) begin
      base_r      <= line_start ? new_base_s : pending_r;
      remaining_r <= RW'(WORDS_PER_LINE);
      abort_r     <= 1'b0;
    end else if (record_s) begin
      pending_r <= new_base_s;
      abort_r   <= 1'b1;
    end else if (state_r == CAPTURE && phase_r) begin
      base_r      <= base_r + ADDR_W'(4);
      remaining_r <= remaining_r - RW'(2);
    end else begin
      base_r <= base_r;
    end
  end

  // Registered video addresses, settle timer, capture phase and done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vid_addr1 <= ADDR_W'(0);
      vid_addr2 <= ADDR_W'(2);
      settle_r  <= SW'(0);
      phase_r   <= 1'b0;
      line_done <= 1'b0;
    end else begin
      if (issue_s) begin
        vid_addr1 <= base_r;
        vid_addr2 <= base_r + ADDR_W'(2);
        settle_r  <= SW'(SETTLE_CYCLES - 1);
      end else if (state_r == WAIT && settle_r != SW'(0)) begin
        settle_r <= settle_r - SW'(1);
      end else begin
        settle_r <= settle_r;
      end
      phase_r   <= (state_r == CAPTURE) ? ~phase_r : 1'b0;
      line_done <= done_s;
    end
  end

  vid_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(WORD_W)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pix_rd),
    .flush     (flush_s),
    .head      (pix_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );
endmodule
